// File: rtl/rx_buffer_selecter.sv
// rx_buffer_selecter
// Receive-side steering of incoming flits into NUM_BUFFERS reassembly buffers.
// Each packet gets its own buffer, chosen by source ID. Each flit is forwarded
// through a registered write port. Completed buffers are reported on
// 'complete' and stay held until the consumer releases them.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   flit handshake from the physical receiver
//   in_flit             flit payload
//   in_flit_type        0=HEAD 1=BODY 2=TAIL 3=HEADTAIL
//   in_src_id           sender node ID
//   buf_we              one-hot write strobe (registered)
//   buf_waddr           flit index inside the selected buffer (registered)
//   buf_wdata           flit data to write (registered)
//   complete            per-buffer "holds a complete packet"
//   buf_src_id          per-buffer source ID, flat, buffer 0 in LSBs
//   buf_len             per-buffer flit count, flat, buffer 0 in LSBs
//   release_valid/idx   consumer returns a COMPLETE buffer to FREE
//   err_drop            one-cycle pulse when an accepted flit was discarded
module rx_buffer_selecter #(
    parameter int NUM_BUFFERS  = 4,
    parameter int FLIT_WIDTH   = 64,
    parameter int SRC_ID_WIDTH = 8,
    parameter int MAX_FLITS    = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [FLIT_WIDTH-1:0]                          in_flit,
    input  logic [1:0]                                     in_flit_type,
    input  logic [SRC_ID_WIDTH-1:0]                        in_src_id,
    output logic [NUM_BUFFERS-1:0]                         buf_we,
    output logic [$clog2(MAX_FLITS)-1:0]                   buf_waddr,
    output logic [FLIT_WIDTH-1:0]                          buf_wdata,
    output logic [NUM_BUFFERS-1:0]                         complete,
    output logic [NUM_BUFFERS*SRC_ID_WIDTH-1:0]            buf_src_id,
    output logic [NUM_BUFFERS*($clog2(MAX_FLITS)+1)-1:0]   buf_len,
    input  logic                                           release_valid,
    input  logic [$clog2(NUM_BUFFERS)-1:0]                 release_idx,
    output logic                                           err_drop
);

    localparam int IDX_W  = $clog2(NUM_BUFFERS);
    localparam int ADDR_W = $clog2(MAX_FLITS);
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        COMPLETE = 2'd2
    } buf_state_t;

    buf_state_t              state_q [NUM_BUFFERS];
    buf_state_t              state_d [NUM_BUFFERS];
    logic [SRC_ID_WIDTH-1:0] src_q   [NUM_BUFFERS];
    logic [SRC_ID_WIDTH-1:0] src_d   [NUM_BUFFERS];
    logic [LEN_W-1:0]        len_q   [NUM_BUFFERS];
    logic [LEN_W-1:0]        len_d   [NUM_BUFFERS];

    logic [NUM_BUFFERS-1:0]  we_d;
    logic [ADDR_W-1:0]       waddr_d;
    logic [FLIT_WIDTH-1:0]   wdata_d;
    logic [NUM_BUFFERS-1:0]  complete_d;
    logic                    drop_d;

    logic                    is_head;
    logic                    is_last;
    logic                    match_hit;
    logic [IDX_W-1:0]        match_idx;
    logic                    free_hit;
    logic [IDX_W-1:0]        free_idx;
    logic                    accept;
    logic [IDX_W-1:0]        head_idx;
    logic [LEN_W-1:0]        cur_len;

    // Lookup of the open packet for this source and the lowest FREE buffer.
    // Both use only pre-edge state, so a buffer released this cycle is not
    // reusable until the next one.
    always_comb begin
        is_head   = (in_flit_type == 2'd0) || (in_flit_type == 2'd3);
        is_last   = (in_flit_type == 2'd2) || (in_flit_type == 2'd3);
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (!match_hit && state_q[i] == FILLING && src_q[i] == in_src_id) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && state_q[i] == FREE) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        // Only a head flit with no buffer to land in is stalled; body/tail
        // flits are always taken and dropped if they have no home.
        in_ready = !(in_valid && is_head && !match_hit && !free_hit);
        accept   = in_valid && in_ready;
        head_idx = match_hit ? match_idx : free_idx;
        cur_len  = len_q[match_idx];
    end

    // Next-state for buffer bookkeeping and the registered write port.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        len_d   = len_q;
        we_d    = '0;
        waddr_d = buf_waddr;
        wdata_d = buf_wdata;
        drop_d  = 1'b0;

        if (accept) begin
            if (is_head) begin
                // A head for a source that already has an open packet
                // restarts that buffer and discards the partial packet.
                drop_d            = match_hit;
                src_d[head_idx]   = in_src_id;
                len_d[head_idx]   = LEN_W'(1);
                state_d[head_idx] = is_last ? COMPLETE : FILLING;
                we_d[head_idx]    = 1'b1;
                waddr_d           = '0;
                wdata_d           = in_flit;
            end else if (match_hit) begin
                if (cur_len == LEN_W'(MAX_FLITS)) begin
                    // No room left: abandon the whole packet.
                    state_d[match_idx] = FREE;
                    len_d[match_idx]   = '0;
                    drop_d             = 1'b1;
                end else begin
                    we_d[match_idx]  = 1'b1;
                    waddr_d          = cur_len[ADDR_W-1:0];
                    wdata_d          = in_flit;
                    len_d[match_idx] = cur_len + LEN_W'(1);
                    if (is_last) begin
                        state_d[match_idx] = COMPLETE;
                    end
                end
            end else begin
                drop_d = 1'b1;
            end
        end

        // State turns COMPLETE at the tail's edge, but the reported flag is
        // registered from it one edge later so the RAM has the last flit.
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            complete_d[i] = (state_q[i] == COMPLETE);
            if (release_valid && release_idx == IDX_W'(i) && state_q[i] == COMPLETE) begin
                state_d[i]    = FREE;
                len_d[i]      = '0;
                complete_d[i] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                state_q[i] <= FREE;
                src_q[i]   <= '0;
                len_q[i]   <= '0;
            end
            buf_we    <= '0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            complete  <= '0;
            err_drop  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            len_q     <= len_d;
            buf_we    <= we_d;
            buf_waddr <= waddr_d;
            buf_wdata <= wdata_d;
            complete  <= complete_d;
            err_drop  <= drop_d;
        end
    end

    // Flatten per-buffer registers onto the status buses.
    always_comb begin
        buf_src_id = '0;
        buf_len    = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            buf_src_id[i*SRC_ID_WIDTH +: SRC_ID_WIDTH] = src_q[i];
            buf_len[i*LEN_W +: LEN_W]                  = len_q[i];
        end
    end

endmodule

// File: tb/tb_rx_buffer_selecter.sv
// tb_rx_buffer_selecter
// Self-checking bench for rx_buffer_selecter with default parameters.
// Every accepted flit pushes its expected write-port/err_drop result; a
// monitor pops and compares one entry per clock, or expects an idle port
// when the queue is empty.
module tb_rx_buffer_selecter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_flit;
    logic [1:0]  in_flit_type;
    logic [7:0]  in_src_id;
    logic [3:0]  buf_we;
    logic [3:0]  buf_waddr;
    logic [63:0] buf_wdata;
    logic [3:0]  complete;
    logic [31:0] buf_src_id;
    logic [19:0] buf_len;
    logic        release_valid;
    logic [1:0]  release_idx;
    logic        err_drop;

    typedef struct {
        logic [3:0]  we;
        logic [3:0]  addr;
        logic [63:0] data;
        logic        drop;
    } exp_t;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;
    logic monOn     = 1'b0;

    localparam logic [1:0] HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HT = 2'd3;

    rx_buffer_selecter dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_flit_type  (in_flit_type),
        .in_src_id     (in_src_id),
        .buf_we        (buf_we),
        .buf_waddr     (buf_waddr),
        .buf_wdata     (buf_wdata),
        .complete      (complete),
        .buf_src_id    (buf_src_id),
        .buf_len       (buf_len),
        .release_valid (release_valid),
        .release_idx   (release_idx),
        .err_drop      (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one flit, require it to be accepted, and record what should come out.
    task automatic applyStimulus(input logic [1:0] t, input logic [7:0] s, input logic [63:0] d,
                                 input logic [3:0] expWe, input logic [3:0] expAddr,
                                 input logic expDrop);
        exp_t e;
        @(negedge clk);
        in_valid     = 1'b1;
        in_flit_type = t;
        in_src_id    = s;
        in_flit      = d;
        #1;
        checkOutput("in_ready", in_ready, 1'b1);
        @(posedge clk);
        e.we   = expWe;
        e.addr = expAddr;
        e.data = d;
        e.drop = expDrop;
        expQ.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic releaseBuf(input logic [1:0] idx);
        @(negedge clk);
        release_valid = 1'b1;
        release_idx   = idx;
        @(posedge clk);
        #1;
        release_valid = 1'b0;
    endtask

    // Scoreboard monitor, sampling 1 ns after every rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (monOn) begin
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("buf_we", buf_we, e.we);
                if (e.we != 4'd0) begin
                    checkOutput("buf_waddr", buf_waddr, e.addr);
                    checkOutput("buf_wdata", buf_wdata, e.data);
                end
                checkOutput("err_drop", err_drop, e.drop);
            end else begin
                checkOutput("idle_we", buf_we, 4'd0);
                checkOutput("idle_drop", err_drop, 1'b0);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_flit       = '0;
        in_flit_type  = HEAD;
        in_src_id     = '0;
        release_valid = 1'b0;
        release_idx   = '0;
        #12;
        checkOutput("rst_we", buf_we, 4'd0);
        checkOutput("rst_complete", complete, 4'd0);
        checkOutput("rst_len", buf_len, 20'd0);
        checkOutput("rst_src", buf_src_id, 32'd0);
        checkOutput("rst_drop", err_drop, 1'b0);
        checkOutput("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst   = 1'b0;
        monOn = 1'b1;

        // Basic three-flit packet.
        applyStimulus(HEAD, 8'd5, 64'hA0, 4'b0001, 4'd0, 1'b0);
        applyStimulus(BODY, 8'd5, 64'hA1, 4'b0001, 4'd1, 1'b0);
        applyStimulus(TAIL, 8'd5, 64'hA2, 4'b0001, 4'd2, 1'b0);
        checkOutput("t1_len", buf_len[4:0], 5'd3);
        checkOutput("t1_src", buf_src_id[7:0], 8'd5);
        checkOutput("t1_cmpl_early", complete, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("t1_cmpl", complete, 4'b0001);
        releaseBuf(2'd0);
        checkOutput("t1_rel_cmpl", complete, 4'b0000);
        checkOutput("t1_rel_len", buf_len[4:0], 5'd0);

        // Fill all buffers, then backpressure until one is released.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(HT, 8'(k + 1), 64'(32'hB0 + k), 4'(1 << k), 4'd0, 1'b0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("t2_cmpl", complete, 4'b1111);
        checkOutput("t2_src", buf_src_id, 32'h04030201);
        checkOutput("t2_len", buf_len, {5'd1, 5'd1, 5'd1, 5'd1});
        @(negedge clk);
        in_valid     = 1'b1;
        in_flit_type = HEAD;
        in_src_id    = 8'd6;
        in_flit      = 64'hC0;
        #1;
        checkOutput("t2_bp", in_ready, 1'b0);
        @(negedge clk);
        release_valid = 1'b1;
        release_idx   = 2'd2;
        #1;
        checkOutput("t2_bp_rel", in_ready, 1'b0);
        @(posedge clk);
        #1;
        release_valid = 1'b0;
        checkOutput("t2_rel_ready", in_ready, 1'b1);
        checkOutput("t2_rel_cmpl", complete, 4'b1011);
        @(posedge clk);
        expQ.push_back('{we: 4'b0100, addr: 4'd0, data: 64'hC0, drop: 1'b0});
        #1;
        in_valid = 1'b0;
        checkOutput("t2_src6", buf_src_id[23:16], 8'd6);
        applyStimulus(TAIL, 8'd6, 64'hC1, 4'b0100, 4'd1, 1'b0);
        @(posedge clk);
        releaseBuf(2'd0);
        releaseBuf(2'd1);
        releaseBuf(2'd2);
        releaseBuf(2'd3);
        checkOutput("t2_all_free", complete, 4'b0000);

        // Interleaved packets from two sources.
        applyStimulus(HEAD, 8'd1, 64'hD0, 4'b0001, 4'd0, 1'b0);
        applyStimulus(HEAD, 8'd2, 64'hE0, 4'b0010, 4'd0, 1'b0);
        applyStimulus(BODY, 8'd1, 64'hD1, 4'b0001, 4'd1, 1'b0);
        applyStimulus(TAIL, 8'd2, 64'hE1, 4'b0010, 4'd1, 1'b0);
        applyStimulus(TAIL, 8'd1, 64'hD2, 4'b0001, 4'd2, 1'b0);
        checkOutput("t3_cmpl_s2", complete, 4'b0010);
        @(posedge clk);
        #1;
        checkOutput("t3_cmpl_both", complete, 4'b0011);
        checkOutput("t3_len", buf_len[9:0], {5'd2, 5'd3});
        releaseBuf(2'd0);
        releaseBuf(2'd1);

        // Orphan body flit.
        applyStimulus(BODY, 8'd9, 64'hF0, 4'b0000, 4'd0, 1'b1);

        // Overflow: the 16th body flit does not fit.
        applyStimulus(HEAD, 8'd3, 64'h300, 4'b0001, 4'd0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(BODY, 8'd3, 64'(32'h300 + k), 4'b0001, 4'(k), 1'b0);
        end
        checkOutput("t5_len_full", buf_len[4:0], 5'd16);
        applyStimulus(BODY, 8'd3, 64'h310, 4'b0000, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("t5_cmpl", complete, 4'b0000);
        // Buffer 0 must be FREE again: a new head takes it with no restart drop.
        applyStimulus(HEAD, 8'd3, 64'h400, 4'b0001, 4'd0, 1'b0);
        applyStimulus(BODY, 8'd3, 64'h401, 4'b0001, 4'd1, 1'b0);

        // Asynchronous reset while buf_we is still high.
        monOn = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_we", buf_we, 4'd0);
        checkOutput("t6_len", buf_len, 20'd0);
        checkOutput("t6_src", buf_src_id, 32'd0);
        checkOutput("t6_cmpl", complete, 4'd0);
        checkOutput("t6_ready", in_ready, 1'b1);
        expQ.delete();
        @(negedge clk);
        rst   = 1'b0;
        monOn = 1'b1;
        applyStimulus(HEAD, 8'd7, 64'h700, 4'b0001, 4'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("q_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
